// File: rtl/hub75_pkg.sv
// Shared constants for the HUB75 BCM driver: FSM encoding, colour-field
// offsets inside a {R,G,B} pixel word, and the panel connector pin order.
package hub75_pkg;

    typedef enum logic [4:0] {
        S_SHIFT   = 5'b00001,
        S_WAIT    = 5'b00010,
        S_LATCH   = 5'b00100,
        S_UNLATCH = 5'b01000,
        S_UNBLANK = 5'b10000
    } state_e;

    // Field index inside a 3*BPC colour word; multiply by BPC for the bit offset.
    localparam int FIELD_R = 2;
    localparam int FIELD_G = 1;
    localparam int FIELD_B = 0;

    // Bit positions on the 16-bit LED_PANEL connector bus.
    localparam int PIN_R0    = 0;
    localparam int PIN_G0    = 1;
    localparam int PIN_B0    = 2;
    localparam int PIN_R1    = 3;
    localparam int PIN_G1    = 4;
    localparam int PIN_B1    = 5;
    localparam int PIN_ADDR  = 6;
    localparam int PIN_BLANK = 11;
    localparam int PIN_LATCH = 12;
    localparam int PIN_SCLK  = 13;

endpackage

// File: rtl/hub75_ontime_timer.sv
// Bit-plane on-time counter: loads the lit duration, counts down to zero
// on its own, and flags when the current plane's time has expired.
module hub75_ontime_timer #(
    parameter int CW = 5
) (
    input  logic          pll_clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge pll_clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver with binary-coded modulation: shifts the next bit-plane
// while the current one is lit, then blanks, latches and relights.
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int ADDR_BITS  = 5,
    parameter int BPC        = 4,
    parameter int ON_UNIT    = 128,
    parameter int FRAME_BITS = 16
) (
    input  logic                       pll_clk,
    input  logic                       reset,
    output logic [$clog2(WIDTH):0]     x,
    output logic [ADDR_BITS:0]         y0,
    output logic [ADDR_BITS:0]         y1,
    output logic [FRAME_BITS-1:0]      frame,
    input  logic [3*BPC-1:0]           rgb0,
    input  logic [3*BPC-1:0]           rgb1,
    output logic [2:0]                 led_rgb0,
    output logic [2:0]                 led_rgb1,
    output logic [ADDR_BITS-1:0]       led_addr,
    output logic                       led_blank,
    output logic                       led_latch,
    output logic                       led_sclk_ena
);

    localparam int XW     = $clog2(WIDTH) + 1;
    localparam int PW     = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int CW_RAW = $clog2(ON_UNIT << (BPC - 1));
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;

    state_e                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d;
    logic [ADDR_BITS-1:0]   row_q, row_d;
    logic [PW-1:0]          plane_q, plane_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [2:0]             rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   blank_q, blank_d;
    logic                   latch_q, latch_d;
    logic                   sclk_q, sclk_d;
    logic                   on_load, on_zero;
    logic [CW-1:0]          on_val;

    function automatic logic [2:0] plane_bits(input logic [3*BPC-1:0] c,
                                              input logic [PW-1:0]    p);
        logic [BPC-1:0] r, g, b;
        r = c[FIELD_R*BPC +: BPC] >> p;
        g = c[FIELD_G*BPC +: BPC] >> p;
        b = c[FIELD_B*BPC +: BPC] >> p;
        return {r[0], g[0], b[0]};
    endfunction

    hub75_ontime_timer #(.CW(CW)) u_timer (
        .pll_clk  (pll_clk),
        .reset    (reset),
        .load     (on_load),
        .load_val (on_val),
        .zero     (on_zero)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        row_d   = row_q;
        plane_d = plane_q;
        frame_d = frame_q;
        rgb0_d  = rgb0_q;
        rgb1_d  = rgb1_q;
        addr_d  = addr_q;
        blank_d = blank_q;
        latch_d = latch_q;
        sclk_d  = sclk_q;
        on_load = 1'b0;
        on_val  = CW'((ON_UNIT << plane_q) - 1);
        case (state_q)
            S_SHIFT: begin
                if (x_q == XW'(WIDTH)) begin
                    sclk_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    rgb0_d = plane_bits(rgb0, plane_q);
                    rgb1_d = plane_bits(rgb1, plane_q);
                    x_d    = x_q + 1'b1;
                    sclk_d = 1'b1;
                end
            end
            S_WAIT: begin
                // Next plane is already shifted; hold it until the lit plane expires.
                if (on_zero) begin
                    blank_d = 1'b1;
                    addr_d  = row_q;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                latch_d = 1'b1;
                state_d = S_UNLATCH;
            end
            S_UNLATCH: begin
                latch_d = 1'b0;
                state_d = S_UNBLANK;
            end
            S_UNBLANK: begin
                blank_d = 1'b0;
                on_load = 1'b1;
                x_d     = '0;
                state_d = S_SHIFT;
                if (plane_q == PW'(BPC - 1)) begin
                    plane_d = '0;
                    row_d   = row_q + 1'b1;
                    if (row_q == '1)
                        frame_d = frame_q + 1'b1;
                end else begin
                    plane_d = plane_q + 1'b1;
                end
            end
            default: state_d = S_SHIFT;
        endcase
    end

    always_ff @(posedge pll_clk) begin
        if (reset) begin
            state_q <= S_SHIFT;
            x_q     <= '0;
            row_q   <= '0;
            plane_q <= '0;
            frame_q <= '0;
            rgb0_q  <= '0;
            rgb1_q  <= '0;
            addr_q  <= '0;
            blank_q <= 1'b1;
            latch_q <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            frame_q <= frame_d;
            rgb0_q  <= rgb0_d;
            rgb1_q  <= rgb1_d;
            addr_q  <= addr_d;
            blank_q <= blank_d;
            latch_q <= latch_d;
            sclk_q  <= sclk_d;
        end
    end

    assign x            = x_q;
    assign y0           = {1'b0, row_q};
    assign y1           = {1'b1, row_q};
    assign frame        = frame_q;
    assign led_rgb0     = rgb0_q;
    assign led_rgb1     = rgb1_q;
    assign led_addr     = addr_q;
    assign led_blank    = blank_q;
    assign led_latch    = latch_q;
    assign led_sclk_ena = sclk_q;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver: WIDTH=8, ADDR_BITS=2, BPC=2, with
// ON_UNIT=16 on the main instance and ON_UNIT=4 on the shift-bound instance.
module tb_hub75_bcm_driver;

    logic pll_clk = 1'b0;
    logic reset   = 1'b1;
    logic rst_s   = 1'b1;

    always #5 pll_clk = ~pll_clk;

    // Painter: R=2'b10 G=2'b01 B=2'b00 top, R=2'b01 G=2'b00 B=2'b11 bottom.
    logic [5:0] rgb0 = 6'b10_01_00;
    logic [5:0] rgb1 = 6'b01_00_11;

    logic [3:0]  x, x_s;
    logic [2:0]  y0, y1, y0_s, y1_s;
    logic [15:0] frame, frame_s;
    logic [2:0]  led_rgb0, led_rgb1, led_rgb0_s, led_rgb1_s;
    logic [1:0]  led_addr, led_addr_s;
    logic        led_blank, led_latch, led_sclk_ena;
    logic        led_blank_s, led_latch_s, led_sclk_ena_s;

    hub75_bcm_driver #(.WIDTH(8), .ADDR_BITS(2), .BPC(2), .ON_UNIT(16), .FRAME_BITS(16)) dut (
        .pll_clk(pll_clk), .reset(reset), .x(x), .y0(y0), .y1(y1), .frame(frame),
        .rgb0(rgb0), .rgb1(rgb1), .led_rgb0(led_rgb0), .led_rgb1(led_rgb1),
        .led_addr(led_addr), .led_blank(led_blank), .led_latch(led_latch),
        .led_sclk_ena(led_sclk_ena)
    );

    hub75_bcm_driver #(.WIDTH(8), .ADDR_BITS(2), .BPC(2), .ON_UNIT(4), .FRAME_BITS(16)) dut_s (
        .pll_clk(pll_clk), .reset(rst_s), .x(x_s), .y0(y0_s), .y1(y1_s), .frame(frame_s),
        .rgb0(rgb0), .rgb1(rgb1), .led_rgb0(led_rgb0_s), .led_rgb1(led_rgb1_s),
        .led_addr(led_addr_s), .led_blank(led_blank_s), .led_latch(led_latch_s),
        .led_sclk_ena(led_sclk_ena_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge pll_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int lit, sc, g, first, hi;
        logic [2:0] e0, e1;

        repeat (3) @(posedge pll_clk);
        #1;
        reset = 1'b0;
        chk("rst_blank", led_blank, 1);
        chk("rst_latch", led_latch, 0);
        chk("rst_sclk",  led_sclk_ena, 0);
        chk("rst_x",     x, 0);
        chk("rst_frame", frame, 0);
        chk("rst_addr",  led_addr, 0);
        chk("rst_rgb0",  led_rgb0, 0);

        // First shift: plane 0 of row 0.
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("sh0_sclk", led_sclk_ena, 1);
            chk("sh0_x", x, k);
            chk("sh0_rgb0", led_rgb0, 3'b010);
            chk("sh0_rgb1", led_rgb1, 3'b101);
            chk("sh0_latch", led_latch, 0);
        end
        step();
        chk("exit_sclk", led_sclk_ena, 0);
        chk("exit_x", x, 8);
        step();
        chk("wait_latch", led_latch, 0);
        chk("wait_blank", led_blank, 1);

        // Eight plane periods: rows 0..3, planes 0,1 each.
        for (int i = 0; i < 8; i++) begin
            step();
            chk("lat_latch", led_latch, 1);
            chk("lat_blank", led_blank, 1);
            chk("lat_addr", led_addr, i / 2);
            chk("lat_y0", y0, i / 2);
            chk("lat_y1", y1, 4 + i / 2);
            step();
            chk("unlat_latch", led_latch, 0);
            chk("unlat_blank", led_blank, 1);
            step();
            chk("unbl_blank", led_blank, 0);
            chk("unbl_frame", frame, (i == 7) ? 1 : 0);
            chk("unbl_x", x, 0);
            e0 = (i % 2 == 0) ? 3'b100 : 3'b010;
            e1 = (i % 2 == 0) ? 3'b001 : 3'b101;
            lit = 0; sc = 0; g = 0;
            while (led_blank == 1'b0 && g < 200) begin
                lit++;
                if (led_sclk_ena) begin
                    sc++;
                    chk("lit_rgb0", led_rgb0, e0);
                    chk("lit_rgb1", led_rgb1, e1);
                end
                step();
                g++;
            end
            chk("lit_len", lit, (i % 2 == 0) ? 16 : 32);
            chk("lit_sclk_cnt", sc, 8);
            chk("rise_latch", led_latch, 0);
        end
        step();
        chk("wrap_latch", led_latch, 1);
        chk("wrap_addr", led_addr, 0);
        chk("wrap_frame", frame, 1);

        // Mid-shift reset at x=4.
        g = 0;
        while (!(x == 4 && led_sclk_ena) && g < 100) begin
            step();
            g++;
        end
        chk("reach_x4", x, 4);
        reset = 1'b1;
        step();
        chk("mrst_blank", led_blank, 1);
        chk("mrst_latch", led_latch, 0);
        chk("mrst_sclk",  led_sclk_ena, 0);
        chk("mrst_x",     x, 0);
        chk("mrst_frame", frame, 0);
        chk("mrst_addr",  led_addr, 0);
        chk("mrst_rgb0",  led_rgb0, 0);
        reset = 1'b0;
        first = 0; sc = 0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (led_sclk_ena) sc++;
            if (led_latch && first == 0) first = k;
        end
        chk("mrst_first_latch", first, 11);
        chk("mrst_sclk_cnt", sc, 8);

        // Shift-bound instance: lit time floors at WIDTH+2.
        rst_s = 1'b0;
        g = 0;
        while (led_blank_s == 1'b1 && g < 50) begin
            step();
            g++;
        end
        chk("sb_unblank0", led_blank_s, 0);
        for (int p = 0; p < 2; p++) begin
            lit = 0; g = 0;
            while (led_blank_s == 1'b0 && g < 100) begin
                lit++;
                step();
                g++;
            end
            chk("sb_lit_len", lit, 10);
            hi = 0; g = 0;
            while (led_blank_s == 1'b1 && g < 100) begin
                hi++;
                step();
                g++;
            end
            chk("sb_blank_len", hi, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
